// File: rtl/dual_slope_sequencer.sv
// Dual-slope ADC conversion sequencer: auto-zero, fixed integrate, deintegrate to comparator trip.
// Outputs are registered except measurement_en_o. There is no backpressure. SEQ_DEADTIME_EN adds 1-cycle all-switches-open DEAD gaps.
module dual_slope_sequencer #(
  parameter int CNT_W       = 12,
  parameter int ZERO_CYCLES = 64,
  parameter int INT_CYCLES  = 2048,
  parameter int MAX_DEINT   = 4095
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic comparator_i,
  output logic measurement_clear_o,
  output logic measurement_en_o,
  output logic sw_zero_o,
  output logic sw_input_o,
  output logic sw_ref_o,
  output logic busy_o,
  output logic done_o,
  output logic overrange_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ZERO  = 3'd1,
    S_INTEG = 3'd2,
    S_DEINT = 3'd3,
    S_DONE  = 3'd4,
    S_DEAD  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  state_t           tgt;
  logic             go;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmp_meta_q, cmp_s_q;
  logic             clear_q, clear_d;
  logic             sw_zero_q, sw_zero_d;
  logic             sw_input_q, sw_input_d;
  logic             sw_ref_q, sw_ref_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
`ifdef SEQ_DEADTIME_EN
  state_t           ret_q, ret_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    clear_d = 1'b0;
    go      = 1'b0;
    tgt     = S_IDLE;
`ifdef SEQ_DEADTIME_EN
    ret_d   = ret_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ZERO;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          clear_d = 1'b1;
        end
      end
      S_ZERO: begin
        if (cnt_q == CNT_W'(ZERO_CYCLES - 1)) begin
          go  = 1'b1;
          tgt = S_INTEG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INTEG: begin
        if (cnt_q == CNT_W'(INT_CYCLES - 1)) begin
          go  = 1'b1;
          tgt = S_DEINT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEINT: begin
        // cnt_q holds the en pulses already issued; stop on trip or on the last allowed pulse
        if (!cmp_s_q) begin
          go  = 1'b1;
          tgt = S_DONE;
        end else if (cnt_q == CNT_W'(MAX_DEINT - 1)) begin
          go    = 1'b1;
          tgt   = S_DONE;
          ovr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef SEQ_DEADTIME_EN
      S_DEAD: state_d = ret_q;
`endif
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      cnt_d = '0;
`ifdef SEQ_DEADTIME_EN
      state_d = S_DEAD;
      ret_d   = tgt;
`else
      state_d = tgt;
`endif
    end

    // Switch and status outputs are registered against the upcoming state
    sw_zero_d  = (state_d == S_IDLE) || (state_d == S_ZERO) || (state_d == S_DONE);
    sw_input_d = (state_d == S_INTEG);
    sw_ref_d   = (state_d == S_DEINT);
    busy_d     = (state_d == S_ZERO) || (state_d == S_INTEG) ||
                 (state_d == S_DEINT) || (state_d == S_DEAD);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
      clear_q    <= 1'b0;
      sw_zero_q  <= 1'b1;
      sw_input_q <= 1'b0;
      sw_ref_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef SEQ_DEADTIME_EN
      ret_q      <= S_IDLE;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmp_meta_q <= comparator_i;
      cmp_s_q    <= cmp_meta_q;
      clear_q    <= clear_d;
      sw_zero_q  <= sw_zero_d;
      sw_input_q <= sw_input_d;
      sw_ref_q   <= sw_ref_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
`ifdef SEQ_DEADTIME_EN
      ret_q      <= ret_d;
`endif
    end
  end

  assign measurement_en_o    = (state_q == S_DEINT) && cmp_s_q;
  assign measurement_clear_o = clear_q;
  assign sw_zero_o           = sw_zero_q;
  assign sw_input_o          = sw_input_q;
  assign sw_ref_o            = sw_ref_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign overrange_o         = ovr_q;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Bench for dual_slope_sequencer: a timeline model of each conversion checked every cycle,
// plus directed runs with hand-computed counts (nominal, overrange, immediate trip, ignored start, reset).
module tb_dual_slope_sequencer;

  localparam int Z = 4;
  localparam int I = 16;
  localparam int M = 32;
`ifdef SEQ_DEADTIME_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  localparam int P_IDLE = 0, P_ZERO = 1, P_INTEG = 2, P_DEINT = 3, P_DEAD = 4, P_DONE = 5;

  logic clk_i, rst_i, start_i, comparator_i;
  logic measurement_clear_o, measurement_en_o, sw_zero_o, sw_input_o, sw_ref_o;
  logic busy_o, done_o, overrange_o;

  int n_err = 0;
  int n_checks = 0;

  dual_slope_sequencer #(
    .CNT_W(12), .ZERO_CYCLES(Z), .INT_CYCLES(I), .MAX_DEINT(M)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .comparator_i(comparator_i),
    .measurement_clear_o(measurement_clear_o), .measurement_en_o(measurement_en_o),
    .sw_zero_o(sw_zero_o), .sw_input_o(sw_input_o), .sw_ref_o(sw_ref_o),
    .busy_o(busy_o), .done_o(done_o), .overrange_o(overrange_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- model: conversion as a timeline from the first ZERO cycle ----------------
  bit m_run, m_ended, m_ovr, m_s1, m_s2, m_prev_deint, m_prev_en;
  int m_t, m_te, m_pulses;
  logic x_clear, x_en, x_zero, x_in, x_ref, x_busy, x_done, x_ovr;

  function automatic int phase_of(bit run, bit ended, int t, int te);
    if (!run) return P_IDLE;
    if (ended) return (t == te + D) ? P_DONE : P_DEAD;
    if (t < Z) return P_ZERO;
    if (D == 1 && t == Z) return P_DEAD;
    if (t < Z + D + I) return P_INTEG;
    if (D == 1 && t == Z + D + I) return P_DEAD;
    return P_DEINT;
  endfunction

  initial begin
    int ph;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        m_run = 0; m_ended = 0; m_ovr = 0; m_s1 = 0; m_s2 = 0;
        m_prev_deint = 0; m_prev_en = 0; m_t = 0; m_te = 0; m_pulses = 0;
      end else begin
        if (m_prev_deint) begin
          if (m_prev_en) m_pulses++;
          if (!m_prev_en || m_pulses == M) begin
            m_ended = 1;
            m_te = m_t + 1;
            if (m_prev_en) m_ovr = 1;
          end
        end
        m_s2 = m_s1;
        m_s1 = comparator_i;
        if (m_run) begin
          if (m_ended && m_t == m_te + D) m_run = 0;
          else m_t++;
        end else if (start_i) begin
          m_run = 1; m_t = 0; m_ended = 0; m_pulses = 0; m_ovr = 0;
        end
      end
      ph = phase_of(m_run, m_ended, m_t, m_te);
      x_clear = m_run && (m_t == 0);
      x_zero  = (ph == P_IDLE) || (ph == P_ZERO) || (ph == P_DONE);
      x_in    = (ph == P_INTEG);
      x_ref   = (ph == P_DEINT);
      x_busy  = (ph == P_ZERO) || (ph == P_INTEG) || (ph == P_DEINT) || (ph == P_DEAD);
      x_done  = (ph == P_DONE);
      x_en    = (ph == P_DEINT) && m_s2;
      x_ovr   = m_ovr;
      m_prev_deint = (ph == P_DEINT);
      m_prev_en    = x_en;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmpb(input string nm, input int cyc, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  int cyc = 0;
  int n_clear, n_done, n_en, n_zb, n_in, n_ref, n_dead, t_clear, t_done;

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        cmpb("clear", cyc, measurement_clear_o, x_clear);
        cmpb("en", cyc, measurement_en_o, x_en);
        cmpb("sw_zero", cyc, sw_zero_o, x_zero);
        cmpb("sw_input", cyc, sw_input_o, x_in);
        cmpb("sw_ref", cyc, sw_ref_o, x_ref);
        cmpb("busy", cyc, busy_o, x_busy);
        cmpb("done", cyc, done_o, x_done);
        cmpb("overrange", cyc, overrange_o, x_ovr);
      end
    end
  end

  // activity counters for the directed literal checks
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i) begin
        if (measurement_clear_o) begin n_clear++; t_clear = cyc; end
        if (done_o) begin n_done++; t_done = cyc; end
        if (measurement_en_o) n_en++;
        if (sw_zero_o && busy_o) n_zb++;
        if (sw_input_o) n_in++;
        if (sw_ref_o) n_ref++;
        if (busy_o && !sw_zero_o && !sw_input_o && !sw_ref_o) n_dead++;
      end
    end
  end

  task automatic clr_mon();
    n_clear = 0; n_done = 0; n_en = 0; n_zb = 0; n_in = 0; n_ref = 0; n_dead = 0;
    t_clear = -1000; t_done = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // leaves the bench 1ns into the first ZERO cycle
  task automatic do_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  // comparator high for exactly the first 10 DEINT cycles (two-flop sync delay)
  task automatic run_nominal(input string tag);
    comparator_i = 1'b1;
    clr_mon();
    do_start();
    tick(28 + 2 * D);
    comparator_i = 1'b0;
    tick(40);
    chk({tag, "_clear_cnt"}, n_clear, 1);
    chk({tag, "_zero_cycles"}, n_zb, 4);
    chk({tag, "_input_cycles"}, n_in, 16);
    chk({tag, "_ref_cycles"}, n_ref, 11);
    chk({tag, "_en_pulses"}, n_en, 10);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_done_time"}, t_done - t_clear, 31 + 3 * D);
    chk({tag, "_dead_cycles"}, n_dead, 3 * D);
    chk({tag, "_ovr"}, int'(overrange_o), 0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    comparator_i = 1'b0;
    clr_mon();
    tick(3);
    rst_i = 1'b0;
    tick(2);
    chk("rst_sw_zero", int'(sw_zero_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_outputs_low", int'({measurement_clear_o, measurement_en_o, sw_input_o,
                                  sw_ref_o, done_o, overrange_o}), 0);

    // 1: nominal conversion
    run_nominal("nom");

    // 2: overrange
    comparator_i = 1'b1;
    clr_mon();
    do_start();
    tick(70);
    chk("ovr_en_pulses", n_en, 32);
    chk("ovr_ref_cycles", n_ref, 32);
    chk("ovr_done_cnt", n_done, 1);
    chk("ovr_done_time", t_done - t_clear, 52 + 3 * D);
    chk("ovr_flag", int'(overrange_o), 1);
    tick(5);
    chk("ovr_held", int'(overrange_o), 1);

    // 3: immediate trip; the accepted start clears overrange
    comparator_i = 1'b0;
    clr_mon();
    do_start();
    chk("trip_ovr_cleared", int'(overrange_o), 0);
    tick(40);
    chk("trip_en_pulses", n_en, 0);
    chk("trip_ref_cycles", n_ref, 1);
    chk("trip_done_time", t_done - t_clear, 21 + 3 * D);
    chk("trip_done_cnt", n_done, 1);

    // 4: start pulsed in INTEG and in DONE is ignored
    comparator_i = 1'b1;
    clr_mon();
    do_start();
    tick(10);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(17 + 2 * D);
    comparator_i = 1'b0;
    tick(3 + D);
    chk("ign_in_done", int'(done_o), 1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(10);
    chk("ign_clear_cnt", n_clear, 1);
    chk("ign_done_cnt", n_done, 1);
    chk("ign_done_time", t_done - t_clear, 31 + 3 * D);
    chk("ign_en_pulses", n_en, 10);
    chk("ign_idle_after", int'(busy_o), 0);

    // 5: reset mid-INTEG aborts immediately, then a full conversion still runs
    comparator_i = 1'b1;
    clr_mon();
    do_start();
    tick(8);
    chk("mid_in_integ", int'(sw_input_o), 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_sw_zero", int'(sw_zero_o), 1);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_others_low", int'({measurement_clear_o, measurement_en_o, sw_input_o,
                                     sw_ref_o, done_o, overrange_o}), 0);
    tick(2);
    rst_i = 1'b0;
    tick(30);
    chk("mid_no_done", n_done, 0);
    chk("mid_no_extra_clear", n_clear, 1);
    run_nominal("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
